// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_loader_pkg
//  Description : Shared constants for the boot-time program loader: FSM state
//                encodings, default word-address width and the byte geometry
//                of a memory word. Imported by mem_loader and mem_loader_pack.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_loader_pkg;

    // Default memory word-address width (capacity 2**12 = 4096 words).
    localparam int c_DEFAULT_ADDR_W = 12;

    // Word geometry: the memory word is always four bytes.
    localparam int c_BYTE_W         = 8;
    localparam int c_BYTES_PER_WORD = 4;
    localparam int c_WORD_BITS      = c_BYTES_PER_WORD * c_BYTE_W;

    // Loader FSM encodings. CHECK is only reachable in checksum builds.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_CHECK  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    // States in which the loader accepts a stream byte. Depends on state
    // only, so there is no combinational path from valid to ready.
    function automatic logic isReadyState(input state_t s);
        return (s == S_LEN_HI) || (s == S_LEN_LO) ||
               (s == S_DATA)   || (s == S_CHECK);
    endfunction

endpackage : mem_loader_pkg
`default_nettype wire

// File: rtl/mem_loader_pack.sv
`default_nettype none
// ============================================================================
//  Module      : mem_loader_pack
//  Description : Little-endian byte-to-word assembler. Keeps the first three
//                bytes of a word in a shift register and a 2-bit byte counter;
//                on the fourth byte it presents the complete word together
//                with a one-cycle wordReady_o strobe.
//  Ports       : clk_i        - clock
//                rst_i        - synchronous active-high reset
//                clear_i      - synchronous clear at the start of a load
//                byteValid_i  - a data byte is transferred this cycle
//                byteData_i   - the transferred byte
//                word_o       - assembled word (valid while wordReady_o)
//                wordReady_o  - fourth byte of a word is being transferred
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_loader_pack
    import mem_loader_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      byteValid_i,
    input  logic [c_BYTE_W-1:0]       byteData_i,
    output logic [c_WORD_BITS-1:0]    word_o,
    output logic                      wordReady_o
);

    localparam int c_SHIFT_W = c_WORD_BITS - c_BYTE_W;

    logic [1:0]           r_count;
    logic [c_SHIFT_W-1:0] r_shift;

    // New bytes enter at the top and move down, so after three bytes the
    // first one sits in bits [7:0] and the fourth completes bits [31:24].
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_count <= 2'd0;
            r_shift <= '0;
        end else if (byteValid_i) begin
            r_shift <= {byteData_i, r_shift[c_SHIFT_W-1:c_BYTE_W]};
            r_count <= r_count + 2'd1;
        end
    end

    assign wordReady_o = byteValid_i && (r_count == 2'(c_BYTES_PER_WORD - 1));
    assign word_o      = {byteData_i, r_shift};

endmodule : mem_loader_pack
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_loader
//  Description : Boot-time program loader. Receives a byte stream
//                (2-byte big-endian word count N, then N little-endian words,
//                plus an optional checksum byte), writes the words to the
//                core's synchronous-write memory from address 0, and holds
//                the core in reset until the image is complete.
//                Optional feature: define MEM_LOADER_CHECKSUM_EN to require a
//                trailing 8-bit sum (mod 256) of all data bytes.
//  Ports       : clk_i, rst_i        - clock, synchronous active-high reset
//                start_i             - begin a load (IDLE/DONE/ERR only)
//                rx_data_i/valid_i   - stream byte and its valid
//                rx_ready_o          - loader accepts a byte this cycle
//                we_o/addr_o/data_o  - memory write port
//                busy_o/done_o/err_o - load status (done/err sticky)
//                cpu_rst_o           - core reset, low only in DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = c_DEFAULT_ADDR_W,
    parameter int DATA_W = 32
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              cpu_rst_o
);

    // Largest accepted image, compared in 32 bits so ADDR_W up to 16
    // cannot truncate the 16-bit stream length.
    localparam logic [31:0] c_MAX_WORDS = 32'd1 << ADDR_W;

    state_t              r_state;
    state_t              w_nextState;
    state_t              w_afterLast;

    logic                w_ready;
    logic                w_xfer;
    logic                w_start;
    logic [7:0]          r_lenHi;
    logic [15:0]         r_len;
    logic [15:0]         w_lenFull;
    logic                w_overflow;
    logic                w_lenZero;
    logic [ADDR_W:0]     r_wordIdx;     // one extra bit: N == 2**ADDR_W must not wrap
    logic                w_lastWord;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                w_packValid;
    logic                w_wordReady;
    logic [c_WORD_BITS-1:0] w_word;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [7:0]          r_sum;
`endif

    // ------------------------------------------------------------------
    // Handshake and decode
    // ------------------------------------------------------------------
    assign w_ready     = isReadyState(r_state);
    assign w_xfer      = rx_valid_i && w_ready;
    assign w_start     = start_i &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    assign w_lenFull   = {r_lenHi, rx_data_i};
    assign w_overflow  = {16'd0, w_lenFull} > c_MAX_WORDS;
    assign w_lenZero   = (w_lenFull == 16'd0);
    assign w_lastWord  = (32'(r_wordIdx) + 32'd1) == {16'd0, r_len};
    assign w_packValid = w_xfer && (r_state == S_DATA);

`ifdef MEM_LOADER_CHECKSUM_EN
    assign w_afterLast = S_CHECK;
`else
    assign w_afterLast = S_DONE;
`endif

    mem_loader_pack u_pack (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (w_start),
        .byteValid_i (w_packValid),
        .byteData_i  (rx_data_i),
        .word_o      (w_word),
        .wordReady_o (w_wordReady)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_nextState = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_xfer) w_nextState = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_xfer) begin
                    if (w_overflow)     w_nextState = S_ERR;
                    else if (w_lenZero) w_nextState = w_afterLast;
                    else                w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wordReady) w_nextState = S_WRITE;
            end
            S_WRITE: begin
                w_nextState = w_lastWord ? w_afterLast : S_DATA;
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_xfer) w_nextState = (rx_data_i == r_sum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE, S_ERR: begin
                if (w_start) w_nextState = S_LEN_HI;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: length, word index, write port registers, checksum
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lenHi   <= 8'd0;
            r_len     <= 16'd0;
            r_wordIdx <= '0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            if (w_start) begin
                r_lenHi   <= 8'd0;
                r_len     <= 16'd0;
                r_wordIdx <= '0;
            end
            if (w_xfer && (r_state == S_LEN_HI)) begin
                r_lenHi <= rx_data_i;
            end
            if (w_xfer && (r_state == S_LEN_LO)) begin
                r_len <= w_lenFull;
            end
            // Address and data are captured on entry to WRITE and then
            // simply held; only we_o qualifies them.
            if (w_wordReady) begin
                r_addr <= r_wordIdx[ADDR_W-1:0];
                r_data <= w_word;
            end
            if (r_state == S_WRITE) begin
                r_wordIdx <= r_wordIdx + 1'b1;
            end
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    // Running sum of data bytes only; the length header is excluded.
    always_ff @(posedge clk_i) begin
        if (rst_i || w_start) begin
            r_sum <= 8'd0;
        end else if (w_packValid) begin
            r_sum <= r_sum + rx_data_i;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs (decoded from the state register)
    // ------------------------------------------------------------------
    assign rx_ready_o = w_ready;
    assign we_o       = (r_state == S_WRITE);
    assign addr_o     = r_addr;
    assign data_o     = r_data;
    assign busy_o     = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
    assign done_o     = (r_state == S_DONE);
    assign err_o      = (r_state == S_ERR);
    assign cpu_rst_o  = (r_state != S_DONE);

endmodule : mem_loader
`default_nettype wire

// File: doc/mem_loader.md
# mem_loader

Boot-time program loader that sits directly upstream of the core's synchronous-write word memory. It accepts a byte stream (from a UART receiver or testbench), assembles little-endian 32-bit words, and drives the memory write port (write enable, write address, write data) sequentially from address 0. It holds the processor in reset until the image is fully written, so a program can be loaded without rebuilding the memory init file.

## Interface
- `ADDR_W`, default 12: memory word-address width; capacity is 2**ADDR_W words.
- `DATA_W`, default 32: memory word width; fixed at 4 bytes and not otherwise supported.
- `clk_i`  in  1: single clock, shared with the memory.
- `rst_i`  in  1: reset, synchronous, active-high.
- `start_i`  in  1: one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- `rx_data_i`  in  8: stream byte.
- `rx_valid_i`  in  1: `rx_data_i` is valid.
- `rx_ready_o`  out  1: loader can take a byte; a transfer occurs when valid and ready are both high.
- `we_o`  out  1: memory write enable.
- `addr_o`  out  ADDR_W: memory write address.
- `data_o`  out  32: memory write data.
- `busy_o`  out  1: load in progress.
- `done_o`  out  1: image loaded successfully; sticky until the next start.
- `err_o`  out  1: load aborted; sticky until the next start.
- `cpu_rst_o`  out  1: hold-reset for the core; high except in DONE.

## Operation
- **Stream format:**
  - 2-byte word count N, big-endian (high byte first).
  - Then N words, 4 bytes each, little-endian: the first byte lands in bits [7:0].
  - With checksum enabled, 1 trailing checksum byte follows.
- **States:** IDLE, LEN_HI, LEN_LO, DATA, WRITE, CHECK (checksum builds only), DONE, ERR.
- **Transitions:**
  - IDLE → LEN_HI on `start_i`.
  - LEN_HI → LEN_LO on a byte transfer.
  - LEN_LO → on a byte transfer:
    - ERR if N > 2**ADDR_W;
    - otherwise DONE (or CHECK) if N == 0;
    - otherwise DATA.
  - DATA: a byte counter counts 0..3. The 4th transfer → WRITE.
  - WRITE (exactly 1 cycle): `we_o`=1, `addr_o`=word index, `data_o`=assembled word. Then the word index increments and:
    - → DATA if words remain;
    - → CHECK or DONE after word N-1.
  - DONE and ERR: `start_i` → LEN_HI. Word index, byte counter, checksum and flags are cleared on that edge.
- **Handshake:**
  - `rx_ready_o`=1 only in LEN_HI, LEN_LO, DATA and CHECK.
  - `rx_valid_i` while not ready is ignored; the source must hold the byte.
  - No combinational path from `rx_valid_i` to `rx_ready_o`.
- `start_i` during LEN_HI..CHECK is ignored.
- `addr_o` and `data_o` hold their last values when `we_o`=0. Only `we_o` qualifies them.
- Maximum image N = 2**ADDR_W (4096 at default). The word index is ADDR_W+1 bits internally, so it does not wrap.

## Timing
- **Reset values:**
  - State IDLE.
  - `we_o`=0, `addr_o`=0, `data_o`=0.
  - `rx_ready_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0.
  - `cpu_rst_o`=1.
  - Counters and checksum = 0.
- Reset mid-load returns to IDLE the next cycle. A partially written image is not rolled back.
- **Throughput:** at most 1 byte per cycle, then 1 ready-low WRITE cycle per word. Minimum is 5 cycles per word.
- The memory write happens on the clock edge ending the WRITE cycle. Data is readable from the memory's async read port in the following cycle.
- `busy_o`=1 in LEN_HI..CHECK.
- `done_o` and the `cpu_rst_o` fall occur in the same cycle the state becomes DONE.
- `cpu_rst_o` rises again in the cycle after `start_i` is taken from DONE.

## Configuration
- Macro `MEM_LOADER_CHECKSUM_EN`.
- **Defined:**
  - An 8-bit running sum (mod 256) covers all data bytes; length bytes are excluded.
  - After the last WRITE, go to CHECK and accept 1 byte.
  - Byte equals sum → DONE; otherwise → ERR.
  - The image is already written in either case; on ERR, `cpu_rst_o` stays 1.
- **Undefined:**
  - No CHECK state, no checksum byte; the last WRITE goes → DONE.
  - ERR is reachable only by the length overflow.

## Structure
- Shared constants header, alongside the core's existing constants include, holds:
  - state encodings;
  - the default word-address width (12);
  - the bytes-per-word constant (4).
- One sub-module is natural: `mem_loader_pack`.
  - Byte shift/assemble register plus 2-bit byte counter, with a `word_ready` strobe.
  - The top holds the FSM, word index, checksum and outputs.

## Test plan
- **Basic load:** after reset, `start_i`; stream 00 02, 78 56 34 12, EF BE AD DE.
  - Expect `we_o` pulses writing addr 0 = 0x12345678 and addr 1 = 0xDEADBEEF.
  - Then `done_o`=1 and `cpu_rst_o`=0.
- **Zero length:** stream 00 00.
  - Expect no `we_o`; DONE right after the 2nd byte (checksum build: CHECK expects byte 00).
- **Overflow:** stream 10 01 (N=4097).
  - Expect ERR, `err_o`=1, no writes, `cpu_rst_o`=1.
  - A later `start_i` clears `err_o` and restarts.
- **Backpressure and gaps:** random `rx_valid_i` gaps.
  - Bytes presented during the WRITE cycle are held and not lost.
  - Memory contents match a model for N=16 random words.
- **Reset mid-load:** `rst_i` asserted after the 6th byte.
  - Next cycle: all outputs at their reset values.
  - A new full load succeeds.
- **Checksum (`MEM_LOADER_CHECKSUM_EN`):** N=1, word 01 02 03 04.
  - Trailing 0A → DONE.
  - Trailing 0B → ERR with addr 0 = 0x04030201 already written.
